rs_encode_stats_log: RTL and testbench
======================================

// Module: rs_encode_stats_log
// PURPOSE
//  Circular on-chip log for RS-encode stats snapshots. Sits directly downstream of the
//  periodic stats recorder: captures every log_wr_req_val/log_wr_req_data beat into a
//  ring RAM, overwriting the oldest entry once full. A read port (val/rdy request,
//  val/rdy response) lets the control/UDP readback path fetch entries by index.
// PARAMETERS
//  LOG_DEPTH_W   6                       log2 of entry count (depth = 64)
//  ENTRY_W       RS_ENC_STATS_STRUCT_W   width of one rs_enc_stats_struct, from package
// PORTS
//  clk                    in   1              single clock domain
//  rst                    in   1              synchronous, active-high reset
//  log_wr_req_val         in   1              snapshot strobe, single cycle, no backpressure
//  log_wr_req_data        in   ENTRY_W        rs_enc_stats_struct snapshot
//  log_rd_req_val         in   1              read request valid
//  log_rd_req_addr        in   LOG_DEPTH_W    logical index; 0 = oldest held entry
//  log_rd_req_rdy         out  1              request accepted when val & rdy
//  log_rd_resp_val        out  1              response valid
//  log_rd_resp_data       out  ENTRY_W        entry contents
//  log_rd_resp_oob        out  1              index >= entries held; data zeroed
//  log_rd_resp_rdy        in   1              consumer ready
//  log_num_entries        out  LOG_DEPTH_W+1  entries held, saturates at 2**LOG_DEPTH_W
//  log_has_wrapped        out  1              at least one entry overwritten since reset
// BEHAVIOUR
//  Reset: wr_ptr=0, log_num_entries=0, log_has_wrapped=0, state=IDLE, log_rd_req_rdy=1,
//   log_rd_resp_val=0, log_rd_resp_data=0, log_rd_resp_oob=0. RAM contents not cleared.
//  Write side, always accepted, never stalls:
//   - On log_wr_req_val: RAM[wr_ptr] <= data; wr_ptr <= wr_ptr+1, mod 2**LOG_DEPTH_W.
//   - log_num_entries increments, saturating at depth.
//   - The write that lands while log_num_entries==depth sets log_has_wrapped (sticky).
//  Read FSM, states IDLE and RESP:
//   - IDLE: log_rd_req_rdy=1. On val & rdy:
//     phys = (full ? wr_ptr : 0) + addr, mod depth; oob = addr >= log_num_entries.
//     RAM read issued that cycle; go to RESP.
//   - RESP: log_rd_req_rdy=0; log_rd_resp_val=1. Data and oob are registered and held
//     stable until log_rd_resp_rdy. On val & rdy go to IDLE.
//     Accept-to-resp_val latency is exactly 1 cycle.
//   - No back-to-back overlap: minimum request spacing is 2 cycles.
//  Arithmetic/width:
//   - Pointer adds wrap naturally at LOG_DEPTH_W bits.
//   - oob compare uses LOG_DEPTH_W+1 bits; oob forces resp_data to 0.
//  Boundaries:
//   - Write and read of the same phys address in the same cycle: the read returns
//     pre-write data (read-first). Oldest-index mapping uses pre-write wr_ptr/count.
//   - Writes that occur in RESP do not alter the held response.
//   - Empty log: every read returns oob=1, data=0.
//   - rst asserted mid-operation: drop to IDLE and clear resp_val the next cycle; any
//     in-flight response is discarded.
// STRUCTURE
//  - rs_encode_stats_defs package (shared with recorder and host decoder):
//    rs_enc_stats_struct, RS_ENC_STATS_STRUCT_W, default LOG_DEPTH_W, read FSM state enum.
//  - Sub-module rs_encode_stats_log_ram: 1R1W synchronous RAM, depth 2**LOG_DEPTH_W,
//    ENTRY_W wide, read-first, registered read data, read enable. No reset.
//  - Top level holds wr_ptr, count, wrap flag, the read FSM and the response hold regs.
// TESTING
//  1. Reset, then read addr 0 -> resp_val next cycle, oob=1, data=0; num_entries=0.
//  2. Write 3 snapshots (timestamps 10,20,30); read addr 0..2 -> 10,20,30, oob=0; addr 3 -> oob=1.
//  3. Write 64+5 snapshots (ts=k); num_entries=64, has_wrapped=1;
//     read addr 0 -> ts=5, addr 63 -> ts=68.
//  4. Read request on the same cycle as a write to the targeted slot -> old value is
//     returned; a reread returns the new value.
//  5. Hold log_rd_resp_rdy=0 for 10 cycles while writes continue -> resp data stable,
//     req_rdy=0 throughout; after rdy, next request accepted one cycle later.
//  6. Assert rst while in RESP -> resp_val=0 and num_entries=0 the next cycle;
//     a subsequent read of addr 0 returns oob=1.

Source files
------------

// File: rtl/rs_encode_stats_log_pkg.sv
// rs_encode_stats_defs: shared RS-encode stats snapshot layout, log defaults and read FSM states
package rs_encode_stats_defs;
  typedef struct packed {
    logic [31:0] timestamp;
    logic [15:0] cw_count;
    logic [15:0] err_count;
  } rs_enc_stats_struct;
  localparam int RS_ENC_STATS_STRUCT_W = $bits(rs_enc_stats_struct);
  localparam int DEF_LOG_DEPTH_W = 6;
  typedef enum logic {IDLE, RESP} log_rd_state_e;
endpackage

// File: rtl/rs_encode_stats_log_ram.sv
// rs_encode_stats_log_ram: 1R1W read-first sync RAM, registered read data; ports: we/waddr/wdata write, re/raddr read, rdata
module rs_encode_stats_log_ram #(
  parameter int AW = 6,
  parameter int DW = 64
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);
  logic [DW-1:0] mem [2**AW];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/rs_encode_stats_log.sv
// rs_encode_stats_log: circular stats snapshot log; ports: log_wr_req_* write beat, log_rd_req_*/log_rd_resp_* indexed readback, log_num_entries/log_has_wrapped status
module rs_encode_stats_log
  import rs_encode_stats_defs::*;
#(
  parameter int LOG_DEPTH_W = DEF_LOG_DEPTH_W,
  parameter int ENTRY_W     = RS_ENC_STATS_STRUCT_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   log_wr_req_val,
  input  logic [ENTRY_W-1:0]     log_wr_req_data,
  input  logic                   log_rd_req_val,
  input  logic [LOG_DEPTH_W-1:0] log_rd_req_addr,
  output logic                   log_rd_req_rdy,
  output logic                   log_rd_resp_val,
  output logic [ENTRY_W-1:0]     log_rd_resp_data,
  output logic                   log_rd_resp_oob,
  input  logic                   log_rd_resp_rdy,
  output logic [LOG_DEPTH_W:0]   log_num_entries,
  output logic                   log_has_wrapped
);
  logic [LOG_DEPTH_W-1:0] wr_ptr, rd_phys;
  logic [ENTRY_W-1:0] ram_rdata;
  logic full, rd_fire, oob_q;
  log_rd_state_e state, state_d;
  assign full = log_num_entries[LOG_DEPTH_W];
  assign rd_fire = log_rd_req_val & log_rd_req_rdy;
  // once full, the oldest entry sits at wr_ptr; pre-write pointer is used so a same-cycle write doesn't shift the mapping
  assign rd_phys = (full ? wr_ptr : '0) + log_rd_req_addr;
  rs_encode_stats_log_ram #(.AW(LOG_DEPTH_W), .DW(ENTRY_W)) u_ram (
    .clk(clk), .we(log_wr_req_val), .waddr(wr_ptr), .wdata(log_wr_req_data),
    .re(rd_fire), .raddr(rd_phys), .rdata(ram_rdata)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      log_num_entries <= '0;
      log_has_wrapped <= 1'b0;
      state <= IDLE;
      oob_q <= 1'b0;
    end else begin
      if (log_wr_req_val) begin
        wr_ptr <= wr_ptr + LOG_DEPTH_W'(1);
        log_num_entries <= log_num_entries + (LOG_DEPTH_W+1)'(!full);
        log_has_wrapped <= log_has_wrapped | full;
      end
      if (rd_fire) oob_q <= {1'b0, log_rd_req_addr} >= log_num_entries;
      state <= state_d;
    end
  end
  always_comb begin
    state_d = state;
    state_d = (state == IDLE) ? (rd_fire ? RESP : IDLE) : (log_rd_resp_rdy ? IDLE : RESP);
  end
  // RAM output register only reloads on an accepted request, so it holds the response through RESP
  assign log_rd_req_rdy = state == IDLE;
  assign log_rd_resp_val = state == RESP;
  assign log_rd_resp_oob = log_rd_resp_val & oob_q;
  assign log_rd_resp_data = (log_rd_resp_val && !oob_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_rs_encode_stats_log.sv
// tb_rs_encode_stats_log: directed self-checking bench for rs_encode_stats_log
module tb_rs_encode_stats_log;
  logic clk = 1'b0, rst = 1'b1;
  logic wr_val = 1'b0, rd_val = 1'b0, resp_rdy = 1'b1;
  logic [63:0] wr_data = '0;
  logic [5:0] rd_addr = '0;
  logic req_rdy, resp_val, resp_oob, has_wrapped;
  logic [63:0] resp_data;
  logic [6:0] num_entries;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  rs_encode_stats_log dut (
    .clk(clk), .rst(rst),
    .log_wr_req_val(wr_val), .log_wr_req_data(wr_data),
    .log_rd_req_val(rd_val), .log_rd_req_addr(rd_addr), .log_rd_req_rdy(req_rdy),
    .log_rd_resp_val(resp_val), .log_rd_resp_data(resp_data), .log_rd_resp_oob(resp_oob),
    .log_rd_resp_rdy(resp_rdy), .log_num_entries(num_entries), .log_has_wrapped(has_wrapped)
  );
  function automatic logic [63:0] mk(int ts);
    logic [31:0] t;
    t = ts;
    return {t, t[15:0] * 16'd3, t[15:0] ^ 16'h5a5a};
  endfunction
  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask
  task automatic wr(int ts);
    wr_val = 1'b1;
    wr_data = mk(ts);
    @(negedge clk);
    wr_val = 1'b0;
  endtask
  task automatic rd(int addr, int ts, bit oob, string tag);
    rd_val = 1'b1;
    rd_addr = 6'(addr);
    @(negedge clk);
    rd_val = 1'b0;
    chk({tag, "_val"}, 64'(resp_val), 64'd1);
    chk({tag, "_oob"}, 64'(resp_oob), 64'(oob));
    chk({tag, "_data"}, resp_data, oob ? 64'd0 : mk(ts));
    @(negedge clk);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_num", 64'(num_entries), 64'd0);
    chk("rst_wrap", 64'(has_wrapped), 64'd0);
    chk("rst_rdy", 64'(req_rdy), 64'd1);
    chk("rst_rval", 64'(resp_val), 64'd0);
    rd(0, 0, 1'b1, "t1_empty");
    wr(10); wr(20); wr(30);
    chk("t2_num", 64'(num_entries), 64'd3);
    rd(0, 10, 1'b0, "t2_a0");
    rd(1, 20, 1'b0, "t2_a1");
    rd(2, 30, 1'b0, "t2_a2");
    rd(3, 0, 1'b1, "t2_a3");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 64; k++) wr(k);
    chk("t3_full_num", 64'(num_entries), 64'd64);
    chk("t3_full_nowrap", 64'(has_wrapped), 64'd0);
    for (int k = 64; k < 69; k++) wr(k);
    chk("t3_num", 64'(num_entries), 64'd64);
    chk("t3_wrap", 64'(has_wrapped), 64'd1);
    rd(0, 5, 1'b0, "t3_a0");
    rd(63, 68, 1'b0, "t3_a63");
    wr_val = 1'b1;
    wr_data = mk(100);
    rd_val = 1'b1;
    rd_addr = 6'd0;
    @(negedge clk);
    wr_val = 1'b0;
    rd_val = 1'b0;
    chk("t4_old", resp_data, mk(5));
    @(negedge clk);
    rd(63, 100, 1'b0, "t4_new");
    resp_rdy = 1'b0;
    rd_val = 1'b1;
    rd_addr = 6'd0;
    @(negedge clk);
    rd_val = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk("t5_hold", resp_data, mk(6));
      chk("t5_rdy0", 64'(req_rdy), 64'd0);
      wr_val = 1'b1;
      wr_data = mk(200 + i);
      @(negedge clk);
    end
    wr_val = 1'b0;
    chk("t5_hold_end", resp_data, mk(6));
    chk("t5_val_end", 64'(resp_val), 64'd1);
    resp_rdy = 1'b1;
    @(negedge clk);
    chk("t5_rdy_back", 64'(req_rdy), 64'd1);
    rd(0, 16, 1'b0, "t5_next");
    resp_rdy = 1'b0;
    rd_val = 1'b1;
    rd_addr = 6'd1;
    @(negedge clk);
    rd_val = 1'b0;
    chk("t6_inresp", 64'(resp_val), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rval", 64'(resp_val), 64'd0);
    chk("t6_num", 64'(num_entries), 64'd0);
    chk("t6_wrap", 64'(has_wrapped), 64'd0);
    chk("t6_rdy", 64'(req_rdy), 64'd1);
    rst = 1'b0;
    resp_rdy = 1'b1;
    rd(0, 0, 1'b1, "t6_empty");
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
